icache_refill_ctrl: RTL

//  Miss/refill controller for one ICACHE bank; consumes the way replacement LFSR output.
//  On a fetch miss it picks a victim way, invalidates that way's tag, and fetches the line from L2.
//  It writes the returned beats into the data SCM, then sets the tag valid.
//  It forwards the critical (missed) word to the fetch unit.

---
 rtl/icache_refill_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//   Miss/refill controller for one ICACHE bank. On an accepted fetch miss it
//   picks a victim way and invalidates that way's tag. It then requests the
//   line from L2 and writes each returned beat into the data SCM. Finally it
//   sets the tag valid. The critical (missed) word is forwarded to the fetch
//   unit one cycle after its beat arrives.
//
//   Optional feature macro: ICACHE_INVALID_WAY_FIRST_EN
//     defined   : prefer the lowest-index invalid way; use the LFSR way only
//                 when the whole set is valid.
//     undefined : always use the LFSR way.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   miss_req_i/addr_i fetch miss request and missing byte address
//   miss_gnt_o        miss accepted (combinational, only in IDLE)
//   way_valid_i       valid bits of the indexed set, sampled at accept
//   lfsr_way_oh_i     one-hot replacement way from the LFSR
//   lfsr_enable_o     1-cycle pulse advancing the LFSR
//   refill_*          L2 line request / grant / in-order beat return
//   tag_*             tag array write port ({valid, tag})
//   data_*            data SCM write port ({index, word offset})
//   fetch_rvalid_o/rdata_o  critical word to fetch unit (1-cycle pulse)
//   busy_o            controller not idle
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned BO        = $clog2(DATA_W / 8),
  localparam int unsigned WO        = $clog2(LINE_WORDS),
  localparam int unsigned IX        = $clog2(NUM_SETS),
  localparam int unsigned TAG_W     = ADDR_W - IX - WO - BO
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_req_i,
  input  logic [ADDR_W-1:0]   miss_addr_i,
  output logic                miss_gnt_o,
  input  logic [NUM_WAYS-1:0] way_valid_i,
  input  logic [NUM_WAYS-1:0] lfsr_way_oh_i,
  output logic                lfsr_enable_o,
  output logic                refill_req_o,
  output logic [ADDR_W-1:0]   refill_addr_o,
  input  logic                refill_gnt_i,
  input  logic                refill_rvalid_i,
  input  logic [DATA_W-1:0]   refill_rdata_i,
  output logic                tag_we_o,
  output logic [NUM_WAYS-1:0] tag_way_oh_o,
  output logic [IX-1:0]       tag_index_o,
  output logic [TAG_W:0]      tag_wdata_o,
  output logic                data_we_o,
  output logic [NUM_WAYS-1:0] data_way_oh_o,
  output logic [IX+WO-1:0]    data_addr_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  output logic                fetch_rvalid_o,
  output logic [DATA_W-1:0]   fetch_rdata_o,
  output logic                busy_o
);

  // Word address width: the byte offset inside a beat is never needed.
  localparam int unsigned AW = ADDR_W - BO;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INVAL,
    S_REQ,
    S_BEATS,
    S_TAG
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [NUM_WAYS-1:0] victim_q, victim_d;
  logic [WO-1:0]       cnt_q, cnt_d;
  logic                lfsr_en_q, lfsr_en_d;
  logic                fetch_rvalid_q, fetch_rvalid_d;
  logic [DATA_W-1:0]   fetch_rdata_q, fetch_rdata_d;

  logic [NUM_WAYS-1:0] victim_c;
  logic                use_lfsr_c;
  logic                tag_valid_c;

  logic [WO-1:0]       word_off;
  logic [IX-1:0]       set_idx;
  logic [TAG_W-1:0]    line_tag;

  // Fields of the latched miss address.
  assign word_off = addr_q[WO-1:0];
  assign set_idx  = addr_q[WO +: IX];
  assign line_tag = addr_q[AW-1 -: TAG_W];

  // Victim selection at accept time.
  always_comb begin : victim_pick
    victim_c   = lfsr_way_oh_i;
    use_lfsr_c = 1'b1;
`ifdef ICACHE_INVALID_WAY_FIRST_EN
    // Descending scan so the lowest-index invalid way wins.
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        victim_c    = '0;
        victim_c[i] = 1'b1;
        use_lfsr_c  = 1'b0;
      end
    end
`endif
  end

`ifndef ICACHE_INVALID_WAY_FIRST_EN
  // Set valid bits only matter when invalid ways are preferred.
  logic unused_way_valid;
  assign unused_way_valid = ^way_valid_i;
`endif

  // Byte-in-beat bits of the miss address are dropped when latching.
  logic unused_miss_addr;
  assign unused_miss_addr = ^miss_addr_i;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      victim_q       <= '0;
      cnt_q          <= '0;
      lfsr_en_q      <= 1'b0;
      fetch_rvalid_q <= 1'b0;
      fetch_rdata_q  <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      victim_q       <= victim_d;
      cnt_q          <= cnt_d;
      lfsr_en_q      <= lfsr_en_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      fetch_rdata_q  <= fetch_rdata_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin : fsm_next
    state_d        = state_q;
    addr_d         = addr_q;
    victim_d       = victim_q;
    cnt_d          = cnt_q;
    lfsr_en_d      = 1'b0;
    fetch_rvalid_d = 1'b0;
    fetch_rdata_d  = fetch_rdata_q;
    miss_gnt_o     = 1'b0;
    refill_req_o   = 1'b0;
    tag_we_o       = 1'b0;
    tag_valid_c    = 1'b0;
    data_we_o      = 1'b0;
    data_wdata_o   = '0;

    case (state_q)
      S_IDLE: begin
        miss_gnt_o = miss_req_i;
        if (miss_req_i) begin
          addr_d    = miss_addr_i[ADDR_W-1:BO];
          victim_d  = victim_c;
          lfsr_en_d = use_lfsr_c;
          cnt_d     = '0;
          state_d   = S_INVAL;
        end
      end

      // Invalidate the victim first so no stale hit can occur mid-refill.
      S_INVAL: begin
        tag_we_o = 1'b1;
        state_d  = S_REQ;
      end

      S_REQ: begin
        refill_req_o = 1'b1;
        if (refill_gnt_i) begin
          state_d = S_BEATS;
        end
      end

      // Beats are written in the cycle they arrive; counter wraps after the last.
      S_BEATS: begin
        if (refill_rvalid_i) begin
          data_we_o    = 1'b1;
          data_wdata_o = refill_rdata_i;
          cnt_d        = cnt_q + WO'(1);
          if (cnt_q == word_off) begin
            fetch_rvalid_d = 1'b1;
            fetch_rdata_d  = refill_rdata_i;
          end
          if (cnt_q == WO'(LINE_WORDS - 1)) begin
            state_d = S_TAG;
          end
        end
      end

      // Whole line is in the SCM: publish the tag as valid.
      S_TAG: begin
        tag_we_o    = 1'b1;
        tag_valid_c = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign lfsr_enable_o  = lfsr_en_q;
  assign refill_addr_o  = {addr_q[AW-1:WO], (WO + BO)'(0)};
  assign tag_way_oh_o   = victim_q;
  assign tag_index_o    = set_idx;
  assign tag_wdata_o    = {tag_valid_c, line_tag};
  assign data_way_oh_o  = victim_q;
  assign data_addr_o    = {set_idx, cnt_q};
  assign fetch_rvalid_o = fetch_rvalid_q;
  assign fetch_rdata_o  = fetch_rdata_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule
